// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Multi-cycle word-wide data memory acting as responder on a
//            req/ack load/store interface. Fixed, parameterised latency,
//            flags misaligned and out-of-range accesses via err_o.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int               CNT_W      = $clog2(LATENCY + 1);
  localparam int               IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(1);
  localparam logic [31:0]      C_DEPTH    = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_ack;
  logic               r_busy;
  logic               r_err;
  logic [31:0]        r_rdata;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_accept;
  logic               w_enter_ack;
  logic               w_acc_we;
  logic [31:0]        w_acc_addr;
  logic [31:0]        w_acc_wdata;
  logic               w_illegal;
  logic [IDX_W-1:0]   w_index;

  // Select the access operands: with LATENCY=1 the access happens on the
  // accepting edge, so the live inputs are used instead of the captured copy.
  always_comb begin
    w_accept    = (r_state == S_IDLE) && req_i;
    w_enter_ack = (w_accept && (LATENCY == 1)) ||
                  ((r_state == S_BUSY) && (r_cnt == C_CNT_LAST));
    if (r_state == S_IDLE) begin
      w_acc_we    = we_i;
      w_acc_addr  = addr_i;
      w_acc_wdata = wdata_i;
    end else begin
      w_acc_we    = r_we;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
    end
    w_illegal = (w_acc_addr[1:0] != 2'b00) ||
                ({2'b00, w_acc_addr[31:2]} >= C_DEPTH);
    w_index   = w_acc_addr[IDX_W+1:2];
  end

  // Control FSM with registered outputs; the read/error result is latched
  // on the edge that enters ACK.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_cnt   <= C_CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= (LATENCY == 1) ? S_ACK : S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - C_CNT_LAST;
          if (r_cnt == C_CNT_LAST) begin
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_enter_ack) begin
        r_ack <= 1'b1;
        r_err <= w_illegal;
        if (w_illegal) begin
          r_rdata <= '0;
        end else if (!w_acc_we) begin
          r_rdata <= r_mem[w_index];
        end
      end
    end
  end

  // Storage array is not reset; a write lands only on a legal ACK entry and
  // is suppressed while reset is asserted so an abandoned store is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_enter_ack && w_acc_we && !w_illegal) begin
      r_mem[w_index] <= w_acc_wdata;
    end
  end

  assign ack_o   = r_ack;
  assign err_o   = r_err;
  assign busy_o  = r_busy;
  assign rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed self-checking bench for data_mem_responder, covering a
//            LATENCY=4 instance and a LATENCY=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req4 = 1'b0, we4 = 1'b0;
  logic [31:0] addr4 = '0, wdata4 = '0;
  logic        ack4, busy4, err4;
  logic [31:0] rdata4;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        ack1, busy1, err1;
  logic [31:0] rdata1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req4), .we_i(we4), .addr_i(addr4),
    .wdata_i(wdata4), .ack_o(ack4), .rdata_o(rdata4), .busy_o(busy4), .err_o(err4)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req1), .we_i(we1), .addr_i(addr1),
    .wdata_i(wdata1), .ack_o(ack1), .rdata_o(rdata1), .busy_o(busy1), .err_o(err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One LATENCY=4 transaction; called #1 after a rising edge with the DUT idle.
  task automatic txn4(input string tag, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_err,
                      input logic [31:0] exp_rd, input bit scramble);
    req4 = 1'b1; we4 = we; addr4 = a; wdata4 = d;
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      if (scramble) begin
        addr4  = $urandom;
        wdata4 = $urandom;
      end
      @(negedge clk);
      check_eq({tag, " busy"}, {31'd0, busy4}, 32'd1);
      check_eq({tag, " ack"}, {31'd0, ack4}, (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) begin
        check_eq({tag, " err"}, {31'd0, err4}, {31'd0, exp_err});
        check_eq({tag, " rdata"}, rdata4, exp_rd);
      end
      @(posedge clk); #1;
    end
    req4 = 1'b0; addr4 = '0; wdata4 = '0;
    @(negedge clk);
    check_eq({tag, " idle busy"}, {31'd0, busy4}, 32'd0);
    check_eq({tag, " idle ack"}, {31'd0, ack4}, 32'd0);
    last_rd = exp_rd;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check_eq("rst ack",   {31'd0, ack4},  32'd0);
    check_eq("rst busy",  {31'd0, busy4}, 32'd0);
    check_eq("rst err",   {31'd0, err4},  32'd0);
    check_eq("rst rdata", rdata4,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic store / load
    txn4("st10",  1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0);
    txn4("ld10",  1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
    // Misaligned load
    txn4("ld13",  1'b0, 32'h13,  32'h0,        1'b1, 32'h0,        1'b0);
    txn4("ld10b", 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
    // Out-of-range store must not alias onto index 0
    txn4("st00",  1'b1, 32'h0,   32'h11111111, 1'b0, last_rd,      1'b0);
    txn4("st400", 1'b1, 32'h400, 32'h12345678, 1'b1, 32'h0,        1'b0);
    txn4("ld00",  1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111, 1'b0);
    txn4("ld400", 1'b0, 32'h400, 32'h0,        1'b1, 32'h0,        1'b0);
    txn4("ld00b", 1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111, 1'b0);

    // Reset in the middle of a store
    txn4("st20a", 1'b1, 32'h20,  32'h0BADC0DE, 1'b0, last_rd,      1'b0);
    req4 = 1'b1; we4 = 1'b1; addr4 = 32'h20; wdata4 = 32'hAAAA5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort ack",   {31'd0, ack4},  32'd0);
    check_eq("abort busy",  {31'd0, busy4}, 32'd0);
    check_eq("abort err",   {31'd0, err4},  32'd0);
    check_eq("abort rdata", rdata4,         32'd0);
    req4 = 1'b0; we4 = 1'b0; addr4 = '0; wdata4 = '0;
    repeat (2) begin
      @(negedge clk);
      check_eq("abort hold ack", {31'd0, ack4}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post rst ack",  {31'd0, ack4},  32'd0);
      check_eq("post rst busy", {31'd0, busy4}, 32'd0);
    end
    @(posedge clk); #1;
    txn4("ld20a", 1'b0, 32'h20,  32'h0,        1'b0, 32'h0BADC0DE, 1'b0);
    txn4("st20b", 1'b1, 32'h20,  32'h1,        1'b0, last_rd,      1'b0);
    txn4("ld20b", 1'b0, 32'h20,  32'h0,        1'b0, 32'h1,        1'b0);

    // Inputs scrambled while busy
    txn4("st08",  1'b1, 32'h08,  32'hCAFEF00D, 1'b0, last_rd,      1'b1);
    txn4("ld08",  1'b0, 32'h08,  32'h0,        1'b0, 32'hCAFEF00D, 1'b0);

    // LATENCY=1: store then back-to-back loads with req held high
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h10; wdata1 = 32'h00000077;
    @(posedge clk); #1;
    we1 = 1'b0; wdata1 = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        check_eq("l1 ack",   {31'd0, ack1},  32'd1);
        check_eq("l1 busy",  {31'd0, busy1}, 32'd1);
        check_eq("l1 err",   {31'd0, err1},  32'd0);
        check_eq("l1 rdata", rdata1, (k == 0) ? 32'h0 : 32'h00000077);
      end else begin
        check_eq("l1 gap ack",  {31'd0, ack1},  32'd0);
        check_eq("l1 gap busy", {31'd0, busy1}, 32'd0);
      end
      @(posedge clk); #1;
    end
    req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data memory that acts as the responder on a request/acknowledge load/store interface.
- The CPU datapath, or a future pipelined MEM stage, is the initiator; this block is the other end.
- It accepts one word-wide read or write at a time, completes it after a fixed, parameterised latency, and flags illegal accesses.
- It replaces the zero-wait combinational memory model so that stall logic can be exercised.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; word index = addr_i[31:2].
- LATENCY, 4, cycles from request acceptance to ack_o; legal range 1..16.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- req_i  input  1  request valid; initiator holds it high until ack_o.
- we_i  input  1  1 = store, 0 = load; sampled with req_i.
- addr_i  input  32  byte address; sampled with req_i.
- wdata_i  input  32  store data; sampled with req_i.
- ack_o  output  1  one-cycle completion pulse.
- rdata_o  output  32  load data; valid when ack_o is high for a load.
- busy_o  output  1  high while a transaction is in flight (BUSY or ACK state).
- err_o  output  1  high with ack_o when the access was illegal.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE, counter = 0, captured request registers = 0.
  - ack_o = 0, busy_o = 0, err_o = 0, rdata_o = 0.
  - Memory array contents are NOT cleared and are undefined until written.
- States: IDLE, BUSY, ACK.
- IDLE: if req_i = 1 at the rising edge:
  - Capture we_i, addr_i, wdata_i into internal registers.
  - Load counter = LATENCY-1.
  - Go to BUSY if LATENCY > 1, else go directly to ACK.
  - Inputs are ignored afterwards until the next IDLE.
- BUSY: decrement counter each edge; when counter = 1, the next state is ACK.
- On the edge entering ACK, the access is performed:
  - Legal load: rdata_o <= mem[index].
  - Legal store: mem[index] <= wdata; rdata_o keeps its previous value.
  - Illegal access: no memory write; rdata_o <= 0; err flag set.
- ACK: ack_o = 1 and err_o = flag for exactly one cycle, then go to IDLE.
- Latency: if req_i is first high in cycle C, ack_o is high in cycle C+LATENCY.
  - busy_o is high in cycles C+1 .. C+LATENCY.
  - The next acceptance is possible at the end of cycle C+LATENCY+1.
  - Minimum one IDLE cycle between transactions.
- Illegal access is either of:
  - addr[1:0] != 0 (misaligned);
  - addr[31:2] >= DEPTH_WORDS (out of range).
  - Both cases produce ack_o with err_o = 1 after the normal LATENCY; there is no early termination.
- rdata_o holds its value between acks; it changes only on entry to ACK for a load or an illegal access.
- The initiator deasserts req_i in the cycle after ack_o.
  - If req_i is still high in the following IDLE cycle, it is accepted as a new transaction. This is legal, not an error.
- Input changes while in BUSY/ACK have no effect, because the captured copies are used.
- Reset mid-BUSY or mid-ACK: transaction abandoned, no write performed, outputs return to reset values immediately.
  - A store abandoned before ACK entry must not modify memory.
- Counter width: clog2(LATENCY+1) bits.
- ack_o, err_o, busy_o and rdata_o are driven from registers/state only, with no combinational path from inputs.

Test Plan:
- LATENCY=4, store 0xDEADBEEF to 0x10, then load from 0x10 → ack_o in cycle C+4 of each; load returns rdata_o = 0xDEADBEEF, err_o = 0; busy_o high exactly 4 cycles per transaction.
- Load from 0x13 (misaligned) → ack_o after 4 cycles with err_o = 1, rdata_o = 0; a following load from 0x10 still returns 0xDEADBEEF.
- DEPTH_WORDS=256, store 0x12345678 to 0x400 (index 256) → err_o = 1, no write; load from 0x000 returns its previously written value unchanged.
- Store 0xAAAA5555 to 0x20; assert rst_i low in cycle C+2 → ack_o never pulses, all outputs 0 immediately; after reset, store 0x1 to 0x20 and read it back = 0x1.
- Change addr_i/wdata_i every cycle during BUSY after accepting store 0xCAFEF00D to 0x08 → load from 0x08 returns 0xCAFEF00D.
- LATENCY=1, keep req_i high continuously with load 0x10 → ack_o pulses every 2 cycles (ack, idle/accept, ack...), busy_o toggles in step.
